// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: fetch state
// encoding, the NOP filler word and the instruction alignment width.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_TRAP = 2'b10
    } fetch_state_t;

    // RISC-V addi x0,x0,0, parked in IF/ID whenever it holds no valid word.
    localparam logic [31:0] NOP_INST_C = 32'h0000_0013;

    // Instructions are 4-byte aligned, so the low two PC bits are always zero.
    localparam int ALIGN_W = 2;

endpackage

// File: rtl/pc_fetch_if_id_reg.sv
// IF/ID holding register. It loads a fetched word when told to advance,
// holds it under decode back-pressure and drops to an invalid NOP on flush.
// Flush has priority over load.
module if_id_reg
    import pc_fetch_pkg::*;
#(
    parameter int                     PC_LENGTH   = 32,
    parameter int                     INST_LENGTH = 32,
    parameter logic [INST_LENGTH-1:0] NOP_INST    = INST_LENGTH'(NOP_INST_C)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   flush,
    input  logic [INST_LENGTH-1:0] in_inst,
    input  logic [PC_LENGTH-1:0]   in_pc,
    output logic                   valid,
    output logic [INST_LENGTH-1:0] inst,
    output logic [PC_LENGTH-1:0]   pc
);

    logic                   valid_r;
    logic [INST_LENGTH-1:0] inst_r;
    logic [PC_LENGTH-1:0]   pc_r;

    // Capture, hold or flush the pipeline word each cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            inst_r  <= NOP_INST;
            pc_r    <= {PC_LENGTH{1'b0}};
        end else if (flush) begin
            valid_r <= 1'b0;
            inst_r  <= NOP_INST;
        end else if (load) begin
            valid_r <= 1'b1;
            inst_r  <= in_inst;
            pc_r    <= in_pc;
        end
    end

    assign valid = valid_r;
    assign inst  = inst_r;
    assign pc    = pc_r;

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: owns the program counter, the BOOT/RUN/TRAP
// state machine and redirect handling, and feeds the IF/ID register.
// Optional feature macro: PC_FETCH_MISALIGN_TRAP_EN (misaligned redirect
// targets trap instead of being silently aligned).
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int                     PC_LENGTH    = 32,
    parameter int                     INST_LENGTH  = 32,
    parameter logic [PC_LENGTH-1:0]   RESET_VECTOR = 32'h0000_0000,
    parameter logic [INST_LENGTH-1:0] NOP_INST     = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [PC_LENGTH-1:0]   PC,
    input  logic [INST_LENGTH-1:0] inst,
    input  logic                   redirect,
    input  logic [PC_LENGTH-1:0]   redirect_target,
    input  logic                   id_ready,
    output logic                   id_valid,
    output logic [INST_LENGTH-1:0] id_inst,
    output logic [PC_LENGTH-1:0]   id_pc,
    output logic                   fetch_fault,
    output logic [PC_LENGTH-1:0]   fault_pc
);

    localparam logic [PC_LENGTH-1:0] ALIGN_MASK =
        {{(PC_LENGTH-ALIGN_W){1'b1}}, {ALIGN_W{1'b0}}};
    localparam logic [PC_LENGTH-1:0] PC_STEP =
        {{(PC_LENGTH-3){1'b0}}, 3'b100};

    fetch_state_t           state_r;
    logic [PC_LENGTH-1:0]   pc_r;
    logic                   advance_s;
    logic                   load_s;
    logic                   flush_s;
    logic [PC_LENGTH-1:0]   aligned_target_s;

    assign advance_s        = !id_valid || id_ready;
    assign aligned_target_s = redirect_target & ALIGN_MASK;

`ifdef PC_FETCH_MISALIGN_TRAP_EN
    logic                   misaligned_s;
    logic                   fetch_fault_r;
    logic [PC_LENGTH-1:0]   fault_pc_r;

    assign misaligned_s = (redirect_target[ALIGN_W-1:0] != {ALIGN_W{1'b0}});
`endif

    // Decide whether IF/ID captures the memory word or is flushed this cycle.
    always_comb begin
        load_s  = 1'b0;
        flush_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (redirect) begin
                    flush_s = 1'b1;
                end else if (advance_s) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            default: begin
                load_s  = 1'b0;
                flush_s = 1'b0;
            end
        endcase
    end

    // PC and state sequencing: one BOOT cycle, then sequential fetch with
    // redirects taking priority over decode back-pressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_BOOT;
            pc_r    <= RESET_VECTOR;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
            fetch_fault_r <= 1'b0;
            fault_pc_r    <= {PC_LENGTH{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_BOOT: begin
                    state_r <= ST_RUN;
                end
                ST_RUN: begin
                    if (redirect) begin
`ifdef PC_FETCH_MISALIGN_TRAP_EN
                        if (misaligned_s) begin
                            state_r       <= ST_TRAP;
                            fetch_fault_r <= 1'b1;
                            fault_pc_r    <= redirect_target;
                        end else begin
                            pc_r <= aligned_target_s;
                        end
`else
                        pc_r <= aligned_target_s;
`endif
                    end else if (advance_s) begin
                        pc_r <= pc_r + PC_STEP;
                    end
                end
                ST_TRAP: begin
                    state_r <= ST_TRAP;
                end
                default: begin
                    state_r <= ST_BOOT;
                end
            endcase
        end
    end

    assign PC = pc_r;

`ifdef PC_FETCH_MISALIGN_TRAP_EN
    assign fetch_fault = fetch_fault_r;
    assign fault_pc    = fault_pc_r;
`else
    assign fetch_fault = 1'b0;
    assign fault_pc    = {PC_LENGTH{1'b0}};
`endif

    if_id_reg #(
        .PC_LENGTH   (PC_LENGTH),
        .INST_LENGTH (INST_LENGTH),
        .NOP_INST    (NOP_INST)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (load_s),
        .flush   (flush_s),
        .in_inst (inst),
        .in_pc   (pc_r),
        .valid   (id_valid),
        .inst    (id_inst),
        .pc      (id_pc)
    );

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch with a combinational memory model
// and a scoreboard of expected post-edge states.
module tb_pc_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] PC;
    logic [31:0] inst;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic        v;
        logic [31:0] ins;
        logic        chk_pc;
        logic [31:0] ipc;
        logic [31:0] pc;
        logic        flt;
        logic [31:0] fpc;
    } exp_t;

    exp_t sb[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h0050_0093;
            32'h0000_0004: mem_word = 32'h0010_0113;
            default:       mem_word = 32'hA500_0000 ^ a;
        endcase
    endfunction

    assign inst = mem_word(PC);

    pc_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .PC              (PC),
        .inst            (inst),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .id_ready        (id_ready),
        .id_valid        (id_valid),
        .id_inst         (id_inst),
        .id_pc           (id_pc),
        .fetch_fault     (fetch_fault),
        .fault_pc        (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic v, input logic [31:0] ins,
                        input logic chk_pc, input logic [31:0] ipc, input logic [31:0] pc,
                        input logic flt, input logic [31:0] fpc);
        exp_t e;
        e.tag = tag; e.v = v; e.ins = ins; e.chk_pc = chk_pc; e.ipc = ipc;
        e.pc = pc; e.flt = flt; e.fpc = fpc;
        sb.push_back(e);
    endtask

    // Advance one edge, then pop and compare the expected post-edge state.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, e.v});
            check({e.tag, ".id_inst"}, id_inst, e.ins);
            if (e.chk_pc) check({e.tag, ".id_pc"}, id_pc, e.ipc);
            check({e.tag, ".PC"}, PC, e.pc);
            check({e.tag, ".fetch_fault"}, {31'd0, fetch_fault}, {31'd0, e.flt});
            check({e.tag, ".fault_pc"}, fault_pc, e.fpc);
        end
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".PC"}, PC, 32'h0);
        check({tag, ".id_valid"}, {31'd0, id_valid}, 32'd0);
        check({tag, ".id_inst"}, id_inst, NOP);
        check({tag, ".id_pc"}, id_pc, 32'h0);
        check({tag, ".fetch_fault"}, {31'd0, fetch_fault}, 32'd0);
        check({tag, ".fault_pc"}, fault_pc, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        redirect = 1'b0;
        redirect_target = 32'h0;
        id_ready = 1'b1;
        #2;
        check_reset_state("reset");
        #10;
        rst = 1'b0;   // released between edges; next edge is the BOOT edge

        // Startup latency: BOOT, then first capture.
        push("boot", 1'b0, NOP, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();
        push("first", 1'b1, 32'h0050_0093, 1'b1, 32'h0, 32'h4, 1'b0, 32'h0);
        tick();
        push("second", 1'b1, 32'h0010_0113, 1'b1, 32'h4, 32'h8, 1'b0, 32'h0);
        tick();

        // Back-pressure: everything frozen for three cycles.
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push("stall", 1'b1, 32'h0010_0113, 1'b1, 32'h4, 32'h8, 1'b0, 32'h0);
            tick();
        end
        id_ready = 1'b1;
        push("resume", 1'b1, mem_word(32'h8), 1'b1, 32'h8, 32'hC, 1'b0, 32'h0);
        tick();

        // Redirect wins over a stalled valid word.
        id_ready = 1'b0;
        redirect = 1'b1;
        redirect_target = 32'h40;
        push("redir", 1'b0, NOP, 1'b0, 32'h0, 32'h40, 1'b0, 32'h0);
        tick();
        redirect = 1'b0;
        push("redir_fill", 1'b1, mem_word(32'h40), 1'b1, 32'h40, 32'h44, 1'b0, 32'h0);
        tick();
        id_ready = 1'b1;

        // Misaligned redirect.
        redirect = 1'b1;
        redirect_target = 32'h42;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        push("trap", 1'b0, NOP, 1'b0, 32'h0, 32'h44, 1'b1, 32'h42);
        tick();
        redirect_target = 32'h80;
        push("trap_redir_ignored", 1'b0, NOP, 1'b0, 32'h0, 32'h44, 1'b1, 32'h42);
        tick();
        redirect = 1'b0;
        push("trap_absorbing", 1'b0, NOP, 1'b0, 32'h0, 32'h44, 1'b1, 32'h42);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("trap_rst");
        @(posedge clk);
        #3;
        rst = 1'b0;
        push("trap_boot", 1'b0, NOP, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();
        push("trap_first", 1'b1, 32'h0050_0093, 1'b1, 32'h0, 32'h4, 1'b0, 32'h0);
        tick();
`else
        push("misalign", 1'b0, NOP, 1'b0, 32'h0, 32'h40, 1'b0, 32'h0);
        tick();
        redirect = 1'b0;
        push("misalign_fill", 1'b1, mem_word(32'h40), 1'b1, 32'h40, 32'h44, 1'b0, 32'h0);
        tick();
`endif

        // PC wrap at the top of the address space.
        redirect = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        push("wrap_redir", 1'b0, NOP, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b0, 32'h0);
        tick();
        redirect = 1'b0;
        push("wrap", 1'b1, mem_word(32'hFFFF_FFFC), 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0);
        tick();
        push("wrap_next", 1'b1, 32'h0050_0093, 1'b1, 32'h0, 32'h4, 1'b0, 32'h0);
        tick();

        // Asynchronous reset between edges, then BOOT with an ignored redirect.
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async_rst");
        @(posedge clk);
        #3;
        rst = 1'b0;
        redirect = 1'b1;
        redirect_target = 32'h80;
        push("boot_redir_ignored", 1'b0, NOP, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();
        redirect = 1'b0;
        push("reboot_first", 1'b1, 32'h0050_0093, 1'b1, 32'h0, 32'h4, 1'b0, 32'h0);
        tick();

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
Instruction-fetch front end sitting directly upstream of the instruction memory. Holds the program counter, drives it to the combinational instruction memory, and captures the returned word into an IF/ID pipeline register. That register is offered to decode over a valid/ready handshake. Handles branch/jump redirects from execute, decode back-pressure, and misaligned redirect targets.

Parameters:
PC_LENGTH, 32, width of the program counter and every address port.
INST_LENGTH, 32, width of the instruction word.
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
NOP_INST, 32'h0000_0013, instruction word held in the IF/ID register when it is invalid (RISC-V addi x0,x0,0).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
PC  output  PC_LENGTH  fetch address to instruction memory; always word-aligned.
inst  input  INST_LENGTH  word returned combinationally by instruction memory for PC.
redirect  input  1  execute requests a control-flow change this cycle.
redirect_target  input  PC_LENGTH  new fetch address, sampled when redirect=1.
id_ready  input  1  decode accepts the IF/ID word this cycle.
id_valid  output  1  IF/ID register holds a valid instruction.
id_inst  output  INST_LENGTH  registered instruction.
id_pc  output  PC_LENGTH  address of id_inst.
fetch_fault  output  1  misaligned redirect trap raised (feature-dependent).
fault_pc  output  PC_LENGTH  offending target while fetch_fault=1.

Behaviour:
- Reset (asynchronous, level): PC=RESET_VECTOR, id_valid=0, id_inst=NOP_INST, id_pc=0, fetch_fault=0, fault_pc=0, state=BOOT. Release is synchronous to the next clk edge.
- States: BOOT, RUN, TRAP.
- BOOT: lasts exactly one cycle after reset deasserts. No capture; id_valid stays 0. Next state is RUN.
- RUN, with advance = !id_valid || id_ready:
  - advance=1: id_inst<=inst, id_pc<=PC, id_valid<=1, PC<=PC+4.
  - advance=0: PC, id_inst, id_pc and id_valid all hold. Output is stable while valid && !ready.
- Redirect priority: redirect=1 in RUN overrides advance. PC<=aligned target and id_valid<=0 in the same edge, whatever id_ready is. The word currently at the memory output is discarded, and id_inst<=NOP_INST.
- Fetch latency: the first valid id_inst appears at edge 2 after reset release (BOOT, then capture). After a redirect, the target's word is in IF/ID one edge after PC takes the target, so there is a 1-bubble penalty.
- A handshake transfer happens when id_valid && id_ready. Back-to-back transfers give one instruction per cycle.
- PC+4 wraps modulo 2^PC_LENGTH with no flag.
- PC[1:0] is always 0, so the memory never returns its high-impedance misaligned response.
- redirect during BOOT is ignored.
- Reset asserted mid-operation returns everything to reset values immediately, including any TRAP.

Optional Feature:
Macro PC_FETCH_MISALIGN_TRAP_EN.
- Defined: a redirect with redirect_target[1:0]!=0 moves RUN to TRAP. fetch_fault<=1, fault_pc<=redirect_target, id_valid<=0. PC holds its previous value. TRAP is absorbing: no captures, redirects ignored, exit only via rst.
- Undefined: redirect_target[1:0] is forced to 0 and execution continues. fetch_fault and fault_pc are tied to 0 and TRAP is unreachable.

Decomposition:
- Shared package: state encoding (BOOT/RUN/TRAP), NOP_INST constant, instruction-alignment width constant (2 bits).
- One natural sub-module, if_id_reg: the valid/ready IF/ID holding register with flush input. pc_fetch owns the PC, state machine and redirect/trap logic.

Test Plan:
- Reset release, id_ready=1, memory word0=0x00500093, word1=0x00100113 -> edge 1 id_valid=0; edge 2 id_valid=1, id_inst=0x00500093, id_pc=0; edge 3 id_inst=0x00100113, id_pc=4; PC=0x8.
- Back-pressure: id_ready=0 for 3 cycles while id_valid=1 at id_pc=0x4 -> id_inst, id_pc and PC frozen (PC=0x8); on id_ready=1 the next edge shows id_pc=0x8.
- Redirect to 0x40 while id_valid=1 and id_ready=0 -> next edge PC=0x40, id_valid=0, id_inst=0x00000013; the following edge shows id_pc=0x40, id_valid=1.
- Misaligned redirect to 0x42: with the macro -> fetch_fault=1, fault_pc=0x42, id_valid=0 permanently, later redirects ignored, rst clears. Without the macro -> PC=0x40, fetch_fault=0.
- Wrap: force PC to 0xFFFF_FFFC via redirect, id_ready=1 -> next PC=0x0000_0000, id_pc=0xFFFF_FFFC.
- rst asserted asynchronously mid-stream (between edges) -> PC=RESET_VECTOR and id_valid=0 immediately, without waiting for clk; BOOT cycle repeats after release.
